// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and types for the VGA raster controller.
//   - DEF_* constants: 640x480 @ 60 Hz default timing (pixels / lines).
//   - H_TOTAL / V_TOTAL and *_START / *_LAST: derived 10-bit phase boundaries.
//   - phase_t: which part of a line/frame a counter value falls in.
//   - ctrl_state_t: controller FSM states.
//   - phase_of(): maps a counter value onto its phase given the boundaries.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic [9:0] H_FP_START   = 10'(DEF_H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(DEF_H_ACTIVE + DEF_H_FP);
  localparam logic [9:0] H_BP_START   = 10'(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(DEF_V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(DEF_V_ACTIVE + DEF_V_FP);
  localparam logic [9:0] V_BP_START   = 10'(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } ctrl_state_t;

  // Phase of a counter value; boundaries are the first value of FP, SYNC and BP.
  function automatic phase_t phase_of(input logic [9:0] cnt,
                                      input logic [9:0] fp_start,
                                      input logic [9:0] sync_start,
                                      input logic [9:0] bp_start);
    phase_t ph;
    if (cnt < fp_start) begin
      ph = PH_ACTIVE;
    end else if (cnt < sync_start) begin
      ph = PH_FP;
    end else if (cnt < bp_start) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BP;
    end
    return ph;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical) position counter.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : advance by one position (wraps after the back porch)
//   clr        : force the count to 0 (has priority over inc)
//   cnt        : current position (registered)
//   phase      : phase of the position the counter holds after this clk edge,
//                so the top can register its decoded outputs in step with cnt
//   wrap       : inc asserted while sitting on the last position
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [9:0] cnt,
  output phase_t     phase,
  output logic       wrap
);

  localparam int         TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [9:0] FP_START   = 10'(ACTIVE);
  localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
  localparam logic [9:0] BP_START   = 10'(ACTIVE + FP + SYNC);
  localparam logic [9:0] LAST       = 10'(TOTAL - 1);

  logic [9:0] cnt_r;
  logic [9:0] cnt_nxt_s;

  // Next position: clear, wrap at the last position, or step by one.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = 10'd0;
    end else if (inc) begin
      if (cnt_r == LAST) begin
        cnt_nxt_s = 10'd0;
      end else begin
        cnt_nxt_s = cnt_r + 10'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt   = cnt_r;
  assign phase = phase_of(cnt_nxt_s, FP_START, SYNC_START, BP_START);
  assign wrap  = inc && (cnt_r == LAST);

endmodule

// File: rtl/vga_ctrl_chk.sv
// vga_ctrl_chk: property checks for vga_ctrl (no logic, observation only).
//   clk, rst_n      : clock and synchronous active-low reset of the controller
//   frame_start,x,y : controller outputs observed by the frame-origin property
module vga_ctrl_chk #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CLK_DIV = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic       frame_start,
  input logic [9:0] x,
  input logic [9:0] y
);

  // Raster totals must fit the 10-bit axis counters.
  a_h_total: assert property (@(posedge clk) H_TOTAL <= 1024);
  a_v_total: assert property (@(posedge clk) V_TOTAL <= 1024);

  // The pixel divider needs an even ratio so vga_clk has a 50% duty cycle.
  a_clk_div: assert property (@(posedge clk) (CLK_DIV >= 2) && ((CLK_DIV % 2) == 0));

  // A frame strobe always marks the raster origin.
  a_frame_origin: assert property (@(posedge clk) disable iff (!rst_n)
    frame_start |-> ((x == 10'd0) && (y == 10'd0)));

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480 @ 60 Hz raster timing controller (timing is parameterised).
//   clk, rst_n  : system clock, synchronous active-low reset
//   en          : scan enable; low returns the controller to idle at once
//   vga_clk     : pixel clock to the DAC, rising mid-pixel
//   hsync/vsync : active-low syncs
//   sync_b      : composite sync to the DAC, tied low
//   blank_b     : high only inside the visible area
//   x, y        : raster position (valid during blanking too)
//   frame_start : one-clk pulse when the position becomes (0,0)
//   line_start  : one-clk pulse when a visible line begins
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       sync_b,
  output logic       blank_b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       line_start
);

  localparam int               LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int               FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int               DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             tick_s;
  logic             vga_clk_r;

  ctrl_state_t      state_r;
  ctrl_state_t      state_nxt_s;
  logic             start_s;
  logic             advance_s;
  logic             clr_s;

  logic [9:0]       h_cnt_s;
  logic [9:0]       v_cnt_s;
  phase_t           h_phase_s;
  phase_t           v_phase_s;
  logic             h_wrap_s;
  logic             v_wrap_s;

  logic             hsync_r;
  logic             vsync_r;
  logic             blank_r;
  logic             frame_start_r;
  logic             line_start_r;

  assign tick_s    = (div_cnt_r == DIV_LAST);
  assign div_nxt_s = tick_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));

  // Pixel divider; vga_clk is derived from the next count so it stays in phase with div_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      vga_clk_r <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      vga_clk_r <= (div_nxt_s >= DIV_HALF);
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: scanning starts on a pixel tick; dropping en stops it on any clk.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && en) begin
          state_nxt_s = ST_SCAN;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (en) begin
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Counters only advance while scanning continues; a start holds them at the origin.
  assign advance_s = (state_r == ST_SCAN) && en && tick_s;
  assign clr_s     = (state_r != ST_SCAN) || (state_nxt_s != ST_SCAN);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (advance_s),
    .clr   (clr_s),
    .cnt   (h_cnt_s),
    .phase (h_phase_s),
    .wrap  (h_wrap_s)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (h_wrap_s),
    .clr   (clr_s),
    .cnt   (v_cnt_s),
    .phase (v_phase_s),
    .wrap  (v_wrap_s)
  );

  // Decoded outputs and strobes, registered on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      blank_r       <= 1'b0;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
    end else begin
      hsync_r       <= !((state_nxt_s == ST_SCAN) && (h_phase_s == PH_SYNC));
      vsync_r       <= !((state_nxt_s == ST_SCAN) && (v_phase_s == PH_SYNC));
      blank_r       <= (state_nxt_s == ST_SCAN) && (h_phase_s == PH_ACTIVE)
                       && (v_phase_s == PH_ACTIVE);
      frame_start_r <= start_s || (advance_s && h_wrap_s && v_wrap_s);
      line_start_r  <= start_s || (advance_s && h_wrap_s && (v_phase_s == PH_ACTIVE));
    end
  end

  assign vga_clk     = vga_clk_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign sync_b      = 1'b0;
  assign blank_b     = blank_r;
  assign x           = h_cnt_s;
  assign y           = v_cnt_s;
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;

  vga_ctrl_chk #(
    .H_TOTAL (LINE_LEN),
    .V_TOTAL (FRAME_LEN),
    .CLK_DIV (CLK_DIV)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start_r),
    .x           (h_cnt_s),
    .y           (v_cnt_s)
  );

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: two controllers (default 640x480/div2 and a shrunk 8x4/div4 raster)
// share clk, rst_n and en. The stimulus process feeds each edge into a raster
// model that derives position from elapsed pixel ticks since scan start and
// queues the expected outputs; a negedge monitor pops and compares them.
module tb_vga_ctrl;

  typedef struct packed {
    logic       vga_clk;
    logic       hsync;
    logic       vsync;
    logic       sync_b;
    logic       blank_b;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       ls;
  } out_t;

  logic clk;
  logic rst_n;
  logic en;

  logic       vga_clk0, hsync0, vsync0, sync_b0, blank_b0, fs0, ls0;
  logic [9:0] x0, y0;
  logic       vga_clk1, hsync1, vsync1, sync_b1, blank_b1, fs1, ls1;
  logic [9:0] x1, y1;

  vga_ctrl dut_big (
    .clk (clk), .rst_n (rst_n), .en (en),
    .vga_clk (vga_clk0), .hsync (hsync0), .vsync (vsync0), .sync_b (sync_b0),
    .blank_b (blank_b0), .x (x0), .y (y0),
    .frame_start (fs0), .line_start (ls0)
  );

  vga_ctrl #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .CLK_DIV  (4)
  ) dut_small (
    .clk (clk), .rst_n (rst_n), .en (en),
    .vga_clk (vga_clk1), .hsync (hsync1), .vsync (vsync1), .sync_b (sync_b1),
    .blank_b (blank_b1), .x (x1), .y (y1),
    .frame_start (fs1), .line_start (ls1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_edges [2];
  bit   m_scan  [2];
  int   m_start [2];
  int   m_h     [2];
  out_t q0[$];
  out_t q1[$];
  bit   done = 1'b0;

  task automatic model_edge(input int id, input bit r, input bit e,
                            input int cd, input int ha, input int hfp, input int hs, input int hbp,
                            input int va, input int vfp, input int vs, input int vbp,
                            output out_t o);
    int ht, vt, el, p, h, v;
    bit fresh;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (!r) begin
      m_edges[id] = 0;
      m_scan[id]  = 1'b0;
    end else begin
      m_edges[id]++;
      if (!e) m_scan[id] = 1'b0;
      else if (!m_scan[id] && (m_edges[id] % cd == 0)) begin
        m_scan[id]  = 1'b1;
        m_start[id] = m_edges[id];
      end
    end
    o = '0;
    o.vga_clk = ((m_edges[id] % cd) >= (cd / 2));
    o.sync_b  = 1'b0;
    o.hsync   = 1'b1;
    o.vsync   = 1'b1;
    m_h[id]   = 0;
    if (m_scan[id]) begin
      el    = m_edges[id] - m_start[id];
      p     = el / cd;
      h     = p % ht;
      v     = (p / ht) % vt;
      fresh = (el % cd == 0);
      m_h[id]   = h;
      o.x       = 10'(h);
      o.y       = 10'(v);
      o.hsync   = !((h >= ha + hfp) && (h < ha + hfp + hs));
      o.vsync   = !((v >= va + vfp) && (v < va + vfp + vs));
      o.blank_b = (h < ha) && (v < va);
      o.fs      = fresh && (h == 0) && (v == 0);
      o.ls      = fresh && (h == 0) && (v < va);
    end
  endtask

  // One clk of stimulus; expected outputs for both DUTs are queued after the edge.
  task automatic cyc(input bit r, input bit e);
    out_t o;
    rst_n = r;
    en    = e;
    @(posedge clk);
    model_edge(0, r, e, 2, 640, 16, 96, 48, 480, 10, 2, 33, o);
    q0.push_back(o);
    model_edge(1, r, e, 4, 8, 1, 2, 1, 4, 1, 2, 1, o);
    q1.push_back(o);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) cyc(1'b1, 1'b1);
    // drop en while the big raster sits at x=300
    for (int i = 0; i < 2000; i++) begin
      if (m_scan[0] && m_h[0] == 300) break;
      cyc(1'b1, 1'b1);
    end
    cyc(1'b1, 1'b0);
    for (int i = 0; i < int'($urandom_range(0, 9)); i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) cyc(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      int on_len;
      int off_len;
      on_len  = int'($urandom_range(20, 2500));
      off_len = int'($urandom_range(1, 6));
      for (int i = 0; i < on_len; i++) cyc(1'b1, 1'b1);
      for (int i = 0; i < off_len; i++) cyc(1'b1, 1'b0);
    end
    for (int i = 0; i < 300; i++) cyc(1'b1, ($urandom % 4) != 0);
    for (int i = 0; i < 1000; i++) cyc(1'b1, 1'b1);
    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'($urandom % 2));
    for (int i = 0; i < 1200; i++) cyc(1'b1, 1'b1);
    done = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  int hs_run = 0;
  bit hs_ok  = 1'b0;
  int ls_gap = 0;
  bit ls_ok  = 1'b0;
  int fs_gap = 0;
  int ls_in_frame = 0;
  bit fs_ok  = 1'b0;

  always @(negedge clk) begin
    out_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("sb_big", 32'({vga_clk0, hsync0, vsync0, sync_b0, blank_b0, x0, y0, fs0, ls0}), 32'(e));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sb_small", 32'({vga_clk1, hsync1, vsync1, sync_b1, blank_b1, x1, y1, fs1, ls1}), 32'(e));
    end

    // hsync low width and line_start spacing on the full-size raster
    if (!m_scan[0]) begin
      hs_ok = 1'b0; hs_run = 0; ls_ok = 1'b0; ls_gap = 0;
    end else begin
      if (!hsync0) hs_run++;
      else begin
        if (hs_ok && hs_run > 0) chk("hsync_low_clk", 32'(hs_run), 32'd192);
        hs_run = 0;
        hs_ok  = 1'b1;
      end
      ls_gap++;
      if (ls0) begin
        if (ls_ok) chk("line_start_gap", 32'(ls_gap), 32'd1600);
        ls_gap = 0;
        ls_ok  = 1'b1;
      end
    end

    // frame spacing and visible-line count on the shrunk raster
    if (!m_scan[1]) begin
      fs_ok = 1'b0; fs_gap = 0; ls_in_frame = 0;
    end else begin
      fs_gap++;
      if (fs1) begin
        if (fs_ok) begin
          chk("frame_start_gap", 32'(fs_gap), 32'd384);
          chk("lines_per_frame", 32'(ls_in_frame), 32'd4);
        end
        fs_gap      = 0;
        ls_in_frame = 0;
        fs_ok       = 1'b1;
      end
      if (ls1) ls_in_frame++;
    end

    if (done) begin
      chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
